sm_seq_divider: RTL and testbench

//   Sequential sign-magnitude divider for the calculator datapath; inverse of the combinational multiplier.

---
 rtl/sm_seq_divider.sv | 153 +++++++++++++++
 tb/tb_sm_seq_divider.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sm_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : sm_seq_divider
//  Purpose  : Sequential sign-magnitude restoring divider, one quotient bit
//             per clock. Divides a sign + 2*MAG_W-bit magnitude dividend by a
//             sign + MAG_W-bit magnitude divisor. Returns a sign-magnitude
//             quotient and remainder through a start/busy/done handshake.
//  Ports    : clk, rst_n (async, active-low)
//             start              - request, sampled only while idle
//             dividend[2W:0]     - [2W] sign, [2W-1:0] magnitude
//             divisor[W:0]       - [W] sign, [W-1:0] magnitude
//             busy               - high while iterating
//             done               - one-cycle pulse, results valid from here
//             quotient[2W:0]     - sign-magnitude quotient (registered)
//             remainder[W:0]     - sign-magnitude remainder (registered)
//             div_by_zero        - divisor magnitude was zero (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module sm_seq_divider #(
    parameter int MAG_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*MAG_W:0]   dividend,
    input  logic [MAG_W:0]     divisor,
    output logic               busy,
    output logic               done,
    output logic [2*MAG_W:0]   quotient,
    output logic [MAG_W:0]     remainder,
    output logic               div_by_zero
);

    localparam int c_N     = 2 * MAG_W;
    localparam int c_CNT_W = $clog2(c_N + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [c_CNT_W-1:0]  cnt_q;
    // Dividend shifts out MSB-first while quotient bits shift in at the LSB,
    // so after c_N iterations this register holds the quotient magnitude.
    logic [c_N-1:0]      dq_q;
    logic [MAG_W-1:0]    dvs_q;
    logic [MAG_W-1:0]    prem_q;
    logic                sdvd_q;
    logic                sdvs_q;
    logic                busy_q;
    logic                done_q;
    logic [2*MAG_W:0]    quo_q;
    logic [MAG_W:0]      rem_q;
    logic                dbz_q;

    // Trial value is the MAG_W+1-bit partial remainder. The stored remainder
    // is always below the divisor, so MAG_W bits suffice between iterations.
    logic [MAG_W:0]      trial_d;
    logic                borrow_d;
    logic [MAG_W-1:0]    prem_d;
    logic [c_N-1:0]      dq_d;
    logic                qsign_d;
    logic                rsign_d;
    logic                dvs_zero_d;

    always_comb begin
        trial_d    = {prem_q, dq_q[c_N-1]};
        borrow_d   = (trial_d < {1'b0, dvs_q});
        // Without a borrow the true difference is below the divisor, so the
        // low MAG_W bits of the modular subtraction are exact.
        prem_d     = borrow_d ? trial_d[MAG_W-1:0] : (trial_d[MAG_W-1:0] - dvs_q);
        dq_d       = {dq_q[c_N-2:0], ~borrow_d};
        qsign_d    = (|dq_d) & (sdvd_q ^ sdvs_q);
        rsign_d    = (|prem_d) & sdvd_q;
        dvs_zero_d = (divisor[MAG_W-1:0] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            sdvd_q  <= 1'b0;
            sdvs_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sdvd_q <= dividend[2*MAG_W];
                        sdvs_q <= divisor[MAG_W];
                        dq_q   <= dividend[2*MAG_W-1:0];
                        dvs_q  <= divisor[MAG_W-1:0];
                        prem_q <= '0;
                        cnt_q  <= '0;
                        if (dvs_zero_d) begin
                            state_q <= S_DONE;
                            quo_q   <= '0;
                            rem_q   <= '0;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= S_CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    dq_q   <= dq_d;
                    prem_q <= prem_d;
                    cnt_q  <= cnt_q + c_CNT_W'(1);
                    if (cnt_q == c_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        quo_q   <= {qsign_d, dq_d};
                        rem_q   <= {rsign_d, prem_d};
                        dbz_q   <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    // A normal result already pulsed done on entry; a
                    // divide-by-zero pulses done one edge later, on exit.
                    done_q  <= dbz_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_sm_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm_seq_divider
//  Purpose  : Scoreboard bench for sm_seq_divider. Stimulus pushes expected
//             results; a monitor pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sm_seq_divider;

    localparam int W  = 2;
    localparam int N  = 2 * W;
    localparam int DW = 2 * W + 1;
    localparam int RW = W + 1;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [RW-1:0] r;
        logic          z;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [RW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [RW-1:0] remainder;
    logic          div_by_zero;

    sm_seq_divider #(.MAG_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   n_done  = 0;
    exp_t sb[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endfunction

    function automatic exp_t mk(logic [DW-1:0] q, logic [RW-1:0] r, logic z);
        exp_t e;
        e.q = q;
        e.r = r;
        e.z = z;
        return e;
    endfunction

    // Reference: plain integer division on magnitudes, then sign rules.
    function automatic exp_t model(logic [DW-1:0] a, logic [RW-1:0] b);
        exp_t e;
        int   dm, vm, qm, rm;
        dm = int'(a[2*W-1:0]);
        vm = int'(b[W-1:0]);
        if (vm == 0) return mk('0, '0, 1'b1);
        qm  = dm / vm;
        rm  = dm % vm;
        e.q = {(qm != 0) && (a[2*W] ^ b[W]), (2*W)'(qm)};
        e.r = {(rm != 0) && a[2*W], W'(rm)};
        e.z = 1'b0;
        return e;
    endfunction

    // Monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_without_start: got done=1, want no done");
            end else begin
                e = sb.pop_front();
                chk("quotient",     32'(quotient),    32'(e.q));
                chk("remainder",    32'(remainder),   32'(e.r));
                chk("div_by_zero",  32'(div_by_zero), 32'(e.z));
                chk("busy_at_done", 32'(busy),        32'd0);
            end
        end
    end

    // One operation: start for one cycle, then scramble the inputs and pulse
    // start once during the calculation, both of which must be ignored.
    task automatic run_op(input logic [DW-1:0] a, input logic [RW-1:0] b, input exp_t e);
        int k;
        int bc;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(e);
        n_acc++;
        @(negedge clk);
        k  = 0;
        bc = 0;
        while (!done && k < 20) begin
            bc       += int'(busy);
            start    = (k == 1);
            dividend = DW'($urandom);
            divisor  = RW'($urandom);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (b[W-1:0] == '0) begin
            chk("dz_latency",     32'(k),  32'd1);
            chk("dz_busy_cycles", 32'(bc), 32'd0);
        end else begin
            chk("latency",     32'(k),  32'(N));
            chk("busy_cycles", 32'(bc), 32'(N));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_done",      32'(done),        32'd0);
        chk("rst_quotient",  32'(quotient),    32'd0);
        chk("rst_remainder", 32'(remainder),   32'd0);
        chk("rst_dbz",       32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        run_op(5'b11001, 3'b010, mk(5'b10100, 3'b101, 1'b0));  // -9 / 2
        run_op(5'b01111, 3'b111, mk(5'b10101, 3'b000, 1'b0));  // 15 / -3
        run_op(5'b00110, 3'b100, mk(5'b00000, 3'b000, 1'b1));  // 6 / 0
        run_op(5'b10000, 3'b111, mk(5'b00000, 3'b000, 1'b0));  // -0 / -3

        // Start 7/2, extra start at edge 2, reset at edge 3: no done at all.
        @(negedge clk);
        start = 1'b1; dividend = 5'b00111; divisor = 3'b010;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 5'b01111; divisor = 3'b011;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy",      32'(busy),        32'd0);
        chk("midrst_done",      32'(done),        32'd0);
        chk("midrst_quotient",  32'(quotient),    32'd0);
        chk("midrst_remainder", 32'(remainder),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_idle", 32'({busy, done}), 32'd0);
        end
        run_op(5'b00111, 3'b010, mk(5'b00011, 3'b001, 1'b0));  // fresh 7 / 2

        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 8; b++)
                run_op(DW'(a), RW'(b), model(DW'(a), RW'(b)));

        for (int i = 0; i < 100; i++) begin
            logic [DW-1:0] ra;
            logic [RW-1:0] rb;
            ra = DW'($urandom);
            rb = RW'($urandom);
            run_op(ra, rb, model(ra, rb));
        end

        repeat (8) @(negedge clk);
        chk("done_count",     32'(n_done),    32'(n_acc));
        chk("scoreboard_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
